uart_serdes: RTL
================

Name: uart_serdes

Overview:
- Serial front end for the board's RS-232 link.
- Converts UART_RXD/UART_TXD bit streams to and from byte handshakes, which are consumed and produced by the debug-memory protocol engine (dbg_uart).
- Contains a 16x-oversampling baud generator, a majority-vote receiver with a small RX FIFO, and a transmitter with a busy handshake.
- Replaces bare bit timing so that back-to-back host bytes survive while the protocol engine stalls.

Parameters:
- DIV, 27, clk cycles per 16x oversample tick (50 MHz / (115200*16)); legal range 2..65535.
- DEPTH_LOG2, 2, RX FIFO depth = 2^DEPTH_LOG2 entries.
- STOPBITS, 1, number of TX stop bits (1 or 2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- nreset  in  1  asynchronous, active-low reset.
- rxd  in  1  raw serial input, asynchronous to clk.
- txd  out  1  serial output, idle high.
- tx_data  in  8  byte to send, sampled when tx_start & !tx_busy.
- tx_start  in  1  request to send tx_data.
- tx_busy  out  1  transmitter occupied.
- rx_data  out  8  head of RX FIFO; valid while rx_avail.
- rx_avail  out  1  RX FIFO not empty.
- rx_rd  in  1  pop RX FIFO head; ignored when !rx_avail.
- rx_overrun  out  1  sticky: byte dropped because FIFO was full.
- frame_err  out  1  sticky: stop bit sampled low.
- err_clr  in  1  clears rx_overrun and frame_err.

Behaviour:

Reset
- Reset is nreset, asynchronous, active-low; clock is clk.
- At reset: txd=1, tx_busy=0, rx_avail=0, rx_data=0, rx_overrun=0, frame_err=0.
- At reset: tick counter=0, FIFO pointers=0, both FSMs in IDLE, rxd synchronizer flops=1.
- Reset mid-frame aborts the frame with no partial byte kept. TX restarts only on a new tx_start.

Tick generator
- Counter runs 0..DIV-1, free-running; tick=1 for one clk when counter==DIV-1, then wraps to 0.
- Bit cell = 16 ticks = 16*DIV clk.

RX synchronizer
- Two-flop synchronizer on rxd; all RX logic uses the synchronized value rs.

RX FSM (states IDLE, START, DATA, STOP, WAITHI; sub-tick counter s = 0..15)
- Bit value = majority of rs sampled at ticks s=7,8,9 of the cell; decision at s=9.
- IDLE: on a tick with rs=0, go START with s=0.
- START: at s=9, majority 1 = glitch, return to IDLE; majority 0 = go DATA at next s=0, bit index 0.
- DATA: 8 bits, LSB first, shifted into the shift register at each s=9. After bit 7, go STOP.
- STOP at s=9, majority 1: push the byte into the FIFO and go IDLE immediately. The remaining ~6 ticks are slack for baud mismatch.
- STOP at s=9, majority 1 with FIFO full and no rx_rd in the same clk: set rx_overrun and discard the byte.
- STOP at s=9, majority 1 with FIFO full and rx_rd in the same clk: the push succeeds.
- STOP at s=9, majority 0: set frame_err, discard the byte, go WAITHI.
- WAITHI: stay until a tick with rs=1, then go IDLE. A break condition yields exactly one frame_err.

RX FIFO
- Depth 2^DEPTH_LOG2; pointers are DEPTH_LOG2+1 bits to tell full from empty.
- rx_data is the combinational head.
- Pop and push in the same clk keep the count unchanged.
- rx_avail updates the clk after a push.

Error flags
- err_clr has priority over a same-cycle error set.

TX FSM (states IDLE, WAIT, START, DATA, STOP)
- IDLE: tx_start=1 latches tx_data; tx_busy=1 from the next clk; go WAIT.
- tx_start while busy is ignored (no queueing).
- WAIT: on the next tick, txd=0 and enter START. Latency from tx_start to txd falling is 1..DIV clk.
- START, DATA (8 bits, LSB first) and STOP (STOPBITS cells, txd=1): 16 ticks each.
- tx_busy drops on the tick ending the last stop cell. A tx_start on that same clk is ignored; the next clk is accepted.

Full duplex
- RX and TX are independent; only the tick is shared.

Test Plan:
- Reset, DIV=27 (bit=432 clk): send 0x55 on rxd at 432-clk bits, rx_rd held 0 -> rx_avail=1 ~9.6 bit times after start edge, rx_data=0x55, flags 0. rx_rd pulse -> rx_avail=0 next clk.
- Pulse tx_start with tx_data=0xA3 -> tx_busy next clk; txd falls within 27 clk; bits LSB first 1,1,0,0,0,1,0,1; stop high. tx_busy low exactly 10*432 clk after txd fall. A second tx_start mid-frame produces no extra frame.
- Receive 5 bytes 0x01..0x05 back-to-back with no rx_rd (DEPTH 4) -> FIFO holds 0x01..0x04, rx_overrun=1. Pop four -> 0x01,0x02,0x03,0x04 in order, rx_avail=0. err_clr -> rx_overrun=0.
- rxd low pulse of 100 clk -> no byte, no frame_err, FSM back to IDLE. Then valid byte 0x3C -> received correctly.
- Frame 0x7E with stop bit low, then rxd held low for 3 bit times -> exactly one frame_err, no FIFO push. rxd high then byte 0x12 -> received normally.
- Assert nreset mid RX byte and mid TX byte -> txd=1, tx_busy=0, rx_avail=0 immediately. Next full frame 0xC9 received as 0xC9.

Source files
------------

// File: rtl/uart_serdes.sv
// uart_serdes: 16x-oversampled UART with majority-vote RX into a small FIFO and a busy-handshake TX.
// One free-running tick generator is shared by both directions.
module uart_serdes #(
    parameter int DIV = 27,
    parameter int DEPTH_LOG2 = 2,
    parameter int STOPBITS = 1
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rxd,
    output logic       txd,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    input  logic       rx_rd,
    output logic       rx_overrun,
    output logic       frame_err,
    input  logic       err_clr
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_WAIT, T_START, T_DATA, T_STOP} tx_state_t;

    logic [15:0] cnt;
    logic tick;
    assign tick = cnt == 16'(DIV - 1);
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 16'd1;

    logic r1, rs;
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) {rs, r1} <= 2'b11;
        else {rs, r1} <= {r1, rxd};

    rx_state_t r_state, r_next;
    logic [3:0] r_s, r_s_d;
    logic [2:0] r_idx, r_idx_d;
    logic [7:0] r_sh, r_sh_d;
    logic [1:0] vote, vote_d;
    logic maj, push, fe_set;
    // Samples at s=7 and s=8 are held; the s=9 sample is the live rs.
    assign maj = (vote[0] & vote[1]) | (rs & (vote[0] | vote[1]));

    always_comb begin
        r_next = r_state;
        r_s_d = r_s;
        r_idx_d = r_idx;
        r_sh_d = r_sh;
        vote_d = vote;
        push = 1'b0;
        fe_set = 1'b0;
        if (tick) begin
            r_s_d = r_s + 4'd1;
            if (r_s == 4'd7) vote_d[0] = rs;
            if (r_s == 4'd8) vote_d[1] = rs;
            case (r_state)
                R_IDLE: if (!rs) begin
                    r_next = R_START;
                    r_s_d = 4'd1;
                end
                R_START: if (r_s == 4'd9) begin
                    r_next = maj ? R_IDLE : R_DATA;
                    r_idx_d = 3'd0;
                end
                R_DATA: if (r_s == 4'd9) begin
                    r_sh_d = {maj, r_sh[7:1]};
                    r_idx_d = r_idx + 3'd1;
                    r_next = r_idx == 3'd7 ? R_STOP : R_DATA;
                end
                R_STOP: if (r_s == 4'd9) begin
                    push = maj;
                    fe_set = !maj;
                    r_next = maj ? R_IDLE : R_WAITHI;
                end
                R_WAITHI: r_next = rs ? R_IDLE : R_WAITHI;
                default: r_next = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            r_state <= R_IDLE;
            r_s <= '0;
            r_idx <= '0;
            r_sh <= '0;
            vote <= 2'b11;
        end else begin
            r_state <= r_next;
            r_s <= r_s_d;
            r_idx <= r_idx_d;
            r_sh <= r_sh_d;
            vote <= vote_d;
        end

    logic [7:0] mem [DEPTH];
    logic [DEPTH_LOG2:0] wp, rp;
    logic pop, full, do_push;
    assign rx_avail = wp != rp;
    assign full = (wp - rp) == (DEPTH_LOG2 + 1)'(DEPTH);
    assign pop = rx_rd & rx_avail;
    // A same-clk pop frees the slot, so a full FIFO can still accept.
    assign do_push = push & (!full | pop);
    assign rx_data = mem[rp[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rx_overrun <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) mem[wp[DEPTH_LOG2-1:0]] <= r_sh;
            wp <= do_push ? wp + 1'b1 : wp;
            rp <= pop ? rp + 1'b1 : rp;
            rx_overrun <= err_clr ? 1'b0 : rx_overrun | (push & !do_push);
            frame_err <= err_clr ? 1'b0 : frame_err | fe_set;
        end

    tx_state_t t_state, t_next;
    logic [3:0] t_s, t_s_d;
    logic [2:0] t_idx, t_idx_d;
    logic [7:0] t_sh, t_sh_d;
    logic t_stop, t_stop_d, cell_end;
    assign cell_end = tick & (t_s == 4'd15);
    assign tx_busy = t_state != T_IDLE;
    assign txd = t_state == T_START ? 1'b0 : t_state == T_DATA ? t_sh[0] : 1'b1;

    always_comb begin
        t_next = t_state;
        t_s_d = tick ? t_s + 4'd1 : t_s;
        t_idx_d = t_idx;
        t_sh_d = t_sh;
        t_stop_d = t_stop;
        case (t_state)
            T_IDLE: if (tx_start) begin
                t_sh_d = tx_data;
                t_next = T_WAIT;
            end
            T_WAIT: if (tick) begin
                t_next = T_START;
                t_s_d = 4'd0;
            end
            T_START: if (cell_end) begin
                t_next = T_DATA;
                t_idx_d = 3'd0;
            end
            T_DATA: if (cell_end) begin
                t_sh_d = t_sh >> 1;
                t_idx_d = t_idx + 3'd1;
                t_stop_d = 1'b0;
                t_next = t_idx == 3'd7 ? T_STOP : T_DATA;
            end
            T_STOP: if (cell_end) begin
                t_stop_d = 1'b1;
                t_next = t_stop == 1'(STOPBITS - 1) ? T_IDLE : T_STOP;
            end
            default: t_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            t_state <= T_IDLE;
            t_s <= '0;
            t_idx <= '0;
            t_sh <= '0;
            t_stop <= 1'b0;
        end else begin
            t_state <= t_next;
            t_s <= t_s_d;
            t_idx <= t_idx_d;
            t_sh <= t_sh_d;
            t_stop <= t_stop_d;
        end
endmodule
